// File: rtl/demux_1to8_deser.sv
// rtl/demux_1to8_deser.sv - registered 1-to-WIDTH demultiplexing deserializer
//
// Ports:
//   clk        system clock, rising-edge state updates
//   rst        asynchronous active-high reset
//   clear      synchronous abort of the partially assembled word
//   in_valid   serial beat present on in_bit
//   in_bit     serial data bit, slot 0 first
//   in_ready   block accepts in_bit this cycle
//   sel        slot the next accepted bit is written to
//   out_valid  out_data holds a complete word
//   out_ready  consumer takes out_data this cycle
//   out_data   assembled word, bit k = k-th accepted bit

module demux_1to8_deser #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic last_slot;
  logic accept;

  assign last_slot = (sel_q == LAST_SLOT);

  // Only the completing bit needs room in the output register; earlier
  // slots never stall.
  assign in_ready = !clear && (!last_slot || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sel_d       = sel_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Consumption first; a word completing in the same edge re-asserts
    // out_valid below, giving back-to-back words without a bubble.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      sel_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (last_slot) begin
        out_data_d            = asm_q;
        out_data_d[WIDTH-1]   = in_bit;
        out_valid_d           = 1'b1;
        asm_d                 = '0;
        sel_d                 = '0;
      end else begin
        asm_d[sel_q] = in_bit;
        sel_d        = sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// tb/tb_demux_1to8_deser.sv - directed self-checking bench for demux_1to8_deser

module tb_demux_1to8_deser;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int vectors;
  int errors;

  demux_1to8_deser dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the partial word is simply the list of bits accepted so far,
  // and the output register is a single optional word.
  bit       m_part[$];
  bit       m_valid;
  bit [7:0] m_data;

  function automatic bit exp_ready();
    return !clear && (m_part.size() != 7 || !m_valid || out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_part.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else begin
      bit acc;
      acc = in_valid && exp_ready();
      if (m_valid && out_ready) m_valid = 1'b0;
      if (clear) begin
        m_part.delete();
      end else if (acc) begin
        m_part.push_back(in_bit);
        if (m_part.size() == 8) begin
          int w;
          w = 0;
          for (int k = 0; k < 8; k++) w += int'(m_part[k]) * (1 << k);
          m_data  = 8'(w);
          m_valid = 1'b1;
          m_part.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: mid-cycle, outputs and inputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sel", int'(sel), m_part.size());
      chk("in_ready", int'(in_ready), int'(exp_ready()));
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) chk("out_data", int'(out_data), int'(m_data));
    end
  end

  task automatic beat(input logic v, input logic b, input logic ordy, input logic clr);
    in_valid  = v;
    in_bit    = b;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic ordy);
    for (int k = 0; k < 8; k++) beat(1'b1, w[k], ordy, 1'b0);
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Single word, out_valid pulses one cycle.
    send_word(8'hD6, 1'b1);
    chk("w1_valid", int'(out_valid), 1);
    chk("w1_data", int'(out_data), 8'hD6);
    chk("w1_model", int'(m_data), 8'hD6);
    chk("w1_sel_wrap", int'(sel), 0);
    beat(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w1_pulse", int'(out_valid), 0);

    // Back-to-back words.
    send_word(8'hD6, 1'b1);
    chk("b2b_a", int'(out_data), 8'hD6);
    send_word(8'h29, 1'b1);
    chk("b2b_b_valid", int'(out_valid), 1);
    chk("b2b_b", int'(out_data), 8'h29);
    chk("b2b_model", int'(m_data), 8'h29);
    beat(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: only the completing bit stalls.
    send_word(8'hD6, 1'b0);
    for (int k = 0; k < 7; k++) beat(1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_sel7", int'(sel), 7);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_hold", int'(out_data), 8'hD6);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_stall_sel", int'(sel), 7);
    chk("bp_stall_data", int'(out_data), 8'hD6);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    chk("bp_ff_valid", int'(out_valid), 1);
    chk("bp_ff", int'(out_data), 8'hFF);
    beat(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear mid-word drops the partial word and the concurrent beat.
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_sel", int'(sel), 0);
    send_word(8'h0F, 1'b1);
    chk("clr_data", int'(out_data), 8'h0F);
    chk("clr_model", int'(m_data), 8'h0F);
    beat(1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset between edges after 5 bits.
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sel", int'(sel), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    #2;
    rst = 1'b0;
    send_word(8'hA5, 1'b1);
    chk("arst_word", int'(out_data), 8'hA5);
    beat(1'b0, 1'b0, 1'b1, 1'b0);

    // Stall with in_bit toggling while in_valid is low.
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) beat(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("stall_sel", int'(sel), 3);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    chk("stall_word", int'(out_data), 8'h3C);
    beat(1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
